// File: rtl/pic_buf_pkg.sv
// Shared types and constants for the picture-buffer sequencer.
// Column step is selected by PIC_BUF_CTRL_STRIDE1_EN (defined: step 1, undefined: step 4).
// No logic here; consumed by pic_buf_ctrl and pic_rd_addr_gen.
package pic_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_SHIFT,
    ST_LOAD,
    ST_DONE
  } state_e;

  localparam int BUF_ROWS      = 4;
  localparam int ROW_BYTES     = 16;
  localparam int WORDS_PER_ROW = 4;

  localparam logic [3:0] LAST_COL  = 4'd15;
  localparam logic [3:0] FIRST_COL = 4'd3;

`ifdef PIC_BUF_CTRL_STRIDE1_EN
  // Overlapping windows: 13 per row position.
  localparam logic [3:0] COL_STEP = 4'd1;
`else
  // Disjoint windows: 4 per row position.
  localparam logic [3:0] COL_STEP = 4'd4;
`endif

  // Buffer column of the first byte written by a given in-row word.
  function automatic logic [3:0] word_col(input logic [1:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/pic_rd_addr_gen.sv
// Word-address counter for image fetches plus the running word index.
// Latency: registered address, updates the edge after load/inc.
// No backpressure of its own; inc is only pulsed on an accepted word.
module pic_rd_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        word_idx
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;

  // Load restarts the sweep at the new base; each accepted word advances both counters.
  // The 4-bit index wraps to 0 after the 16-word fill, so its low 2 bits stay row-aligned for loads.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = base_addr;
      cnt_d  = 4'd0;
    end else if (inc) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_addr = addr_q;
  assign word_idx = cnt_q;

endmodule

// File: rtl/pic_buf_ctrl.sv
// Sequencer for the 4x16-byte sliding picture buffer: fill, read windows, shift, load, repeat.
// Latency: mem_rd the cycle after start; win_valid in the first READ cycle (window is combinational).
// Backpressure: mem_rd/mem_addr held until mem_valid; j/win_valid held while win_ready is low.
// Column step set by PIC_BUF_CTRL_STRIDE1_EN (see pic_buf_pkg).
module pic_buf_ctrl
  import pic_buf_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int IMG_ROWS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  output logic              buf_we,
  output logic              buf_re,
  output logic              buf_shift,
  output logic [1:0]        buf_i,
  output logic [3:0]        buf_j,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last
);

  // Holds 0..IMG_ROWS; saturates at IMG_ROWS.
  localparam int ROW_W = $clog2(IMG_ROWS + 1);

  state_e           state_q, state_d;
  logic [3:0]       j_q, j_d;
  logic [ROW_W-1:0] rows_q, rows_d;

  logic       addr_load;
  logic       word_acc;
  logic [3:0] word_idx;
  logic       last_rows;

  assign last_rows = (rows_q >= ROW_W'(IMG_ROWS));
  assign word_acc  = mem_rd & mem_valid;
  assign busy      = (state_q != ST_IDLE);

  pic_rd_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .base_addr(base_addr),
    .inc      (word_acc),
    .mem_addr (mem_addr),
    .word_idx (word_idx)
  );

  // Next state, counters and all buffer/memory controls; outputs default low so IDLE is all zero.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    rows_d    = rows_q;
    addr_load = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    buf_we    = 1'b0;
    buf_re    = 1'b0;
    buf_shift = 1'b0;
    buf_i     = 2'd0;
    buf_j     = 4'd0;
    win_valid = 1'b0;
    win_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_load = 1'b1;
          rows_d    = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_rd = 1'b1;
        buf_we = mem_valid;
        buf_i  = word_idx[3:2];
        buf_j  = word_col(word_idx[1:0]);
        if (mem_valid && (word_idx == 4'd15)) begin
          rows_d  = ROW_W'(BUF_ROWS);
          j_d     = FIRST_COL;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        buf_re    = 1'b1;
        win_valid = 1'b1;
        buf_j     = j_q;
        win_last  = (j_q == LAST_COL) && last_rows;
        if (win_ready) begin
          if (j_q == LAST_COL) begin
            state_d = last_rows ? ST_DONE : ST_SHIFT;
          end else begin
            j_d = j_q + COL_STEP;
          end
        end
      end
      ST_SHIFT: begin
        buf_shift = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        mem_rd = 1'b1;
        buf_we = mem_valid;
        buf_i  = 2'd3;
        buf_j  = word_col(word_idx[1:0]);
        if (mem_valid && (word_idx[1:0] == 2'd3)) begin
          rows_d  = last_rows ? rows_q : rows_q + ROW_W'(1);
          j_d     = FIRST_COL;
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= 4'd0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      rows_q  <= rows_d;
    end
  end

endmodule

// File: tb/tb_pic_buf_ctrl.sv
// Directed bench for pic_buf_ctrl with a 6-row image: fill, windows, stalls, shifts, reset, restart.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Summary line reports errors and total checks.
module tb_pic_buf_ctrl;

  localparam int ADDR_W   = 16;
  localparam int IMG_ROWS = 6;
`ifdef PIC_BUF_CTRL_STRIDE1_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 4;
`endif
  localparam int N_WIN = (15 - 3) / STEP + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, done, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic              buf_we, buf_re, buf_shift;
  logic [1:0]        buf_i;
  logic [3:0]        buf_j;
  logic              win_valid, win_ready, win_last;

  int errors = 0;
  int checks = 0;
  int shift_cnt = 0;
  int win_cnt = 0;

  pic_buf_ctrl #(
    .ADDR_W  (ADDR_W),
    .IMG_ROWS(IMG_ROWS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .busy     (busy),
    .done     (done),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_valid(mem_valid),
    .buf_we   (buf_we),
    .buf_re   (buf_re),
    .buf_shift(buf_shift),
    .buf_i    (buf_i),
    .buf_j    (buf_j),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_last (win_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_shift) shift_cnt <= shift_cnt + 1;
    if (win_valid && win_ready) win_cnt <= win_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_we"}, buf_we, 0);
    chk({tag, "_re"}, buf_re, 0);
    chk({tag, "_shift"}, buf_shift, 0);
    chk({tag, "_i"}, buf_i, 0);
    chk({tag, "_j"}, buf_j, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_last"}, win_last, 0);
  endtask

  // One memory word: dly wait cycles with request held, then one valid cycle.
  task automatic word(input logic [15:0] a, input logic [1:0] ei, input logic [3:0] ej,
                      input int dly, input string tag);
    for (int d = 0; d < dly; d++) begin
      mem_valid = 1'b0;
      #1;
      chk({tag, "_wait_rd"}, mem_rd, 1);
      chk({tag, "_wait_addr"}, mem_addr, a);
      chk({tag, "_wait_we"}, buf_we, 0);
      @(negedge clk);
    end
    mem_valid = 1'b1;
    #1;
    chk({tag, "_rd"}, mem_rd, 1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_we"}, buf_we, 1);
    chk({tag, "_i"}, buf_i, ei);
    chk({tag, "_j"}, buf_j, ej);
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  // One accepted window.
  task automatic win(input logic [3:0] ej, input logic elast, input string tag);
    win_ready = 1'b1;
    #1;
    chk({tag, "_valid"}, win_valid, 1);
    chk({tag, "_re"}, buf_re, 1);
    chk({tag, "_j"}, buf_j, ej);
    chk({tag, "_last"}, win_last, elast);
    chk({tag, "_we"}, buf_we, 0);
    @(negedge clk);
    win_ready = 1'b0;
  endtask

  task automatic shift_cycle(input string tag);
    #1;
    chk({tag, "_shift"}, buf_shift, 1);
    chk({tag, "_re"}, buf_re, 0);
    chk({tag, "_we"}, buf_we, 0);
    chk({tag, "_rd"}, mem_rd, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    int w0, s0;
    logic [15:0] a;
    rst = 1'b1; start = 1'b0; base_addr = '0; mem_valid = 1'b0; win_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Sweep 1: base 0x100, 6 rows.
    w0 = win_cnt; s0 = shift_cnt;
    start = 1'b1; base_addr = 16'h0100;
    #1;
    chk("start_busy_same_cycle", busy, 0);
    chk("start_rd_same_cycle", mem_rd, 0);
    @(negedge clk);
    start = 1'b0; base_addr = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      a = 16'h0100 + 16'(k);
      if (k == 2) begin
        start = 1'b1; base_addr = 16'h0200;
      end
      word(a, 2'(k / 4), 4'((k % 4) * 4), (k == 5) ? 3 : 0, "fill");
      start = 1'b0; base_addr = 16'h0000;
    end
    for (int pos = 0; pos < 3; pos++) begin
      for (int j = 3; j <= 15; j += STEP) begin
        if (pos == 0 && j == 7) begin
          for (int s = 0; s < 5; s++) begin
            win_ready = 1'b0; mem_valid = 1'b1;
            #1;
            chk("stall_valid", win_valid, 1);
            chk("stall_re", buf_re, 1);
            chk("stall_j", buf_j, 7);
            chk("stall_we_ignored", buf_we, 0);
            chk("stall_rd", mem_rd, 0);
            @(negedge clk);
          end
          mem_valid = 1'b0;
        end
        win(4'(j), (pos == 2) && (j == 15), "win");
      end
      if (pos < 2) begin
        shift_cycle("shift");
        for (int k = 0; k < 4; k++) begin
          a = 16'h0110 + 16'(pos * 4 + k);
          word(a, 2'd3, 4'(k * 4), (pos == 1 && k == 0) ? 3 : 0, "load");
        end
      end
    end
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_rd", mem_rd, 0);
    @(negedge clk);
    #1;
    chk("after_done_pulse", done, 0);
    chk("after_done_busy", busy, 0);
    chk("sweep_windows", win_cnt - w0, 3 * N_WIN);
    chk("sweep_shifts", shift_cnt - s0, 2);
    @(negedge clk);

    // Sweep 2: reset during the third word of the first load.
    start = 1'b1; base_addr = 16'h0300;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++)
      word(16'h0300 + 16'(k), 2'(k / 4), 4'((k % 4) * 4), 0, "fill2");
    for (int j = 3; j <= 15; j += STEP)
      win(4'(j), 1'b0, "win2");
    shift_cycle("shift2");
    word(16'h0310, 2'd3, 4'd0, 0, "load2");
    word(16'h0311, 2'd3, 4'd4, 0, "load2");
    rst = 1'b1;
    #1;
    chk("pre_rst_rd", mem_rd, 1);
    chk("pre_rst_addr", mem_addr, 16'h0312);
    @(negedge clk);
    #1;
    chk_idle("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0400;
    @(negedge clk);
    start = 1'b0;
    word(16'h0400, 2'd0, 4'd0, 0, "restart");
    word(16'h0401, 2'd0, 4'd4, 0, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
